// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state encoding and default widths for the cache requester
package cache_pkg;

    localparam int CACHE_ADDR_WIDTH = 12;
    localparam int CACHE_DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        CHECK    = 3'd2,
        MEM_RD   = 3'd3,
        FILL     = 3'd4,
        WR_CACHE = 3'd5,
        WR_MEM   = 3'd6,
        RESP     = 3'd7
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cache_requester.sv
// rtl/cache_requester.sv - CPU-side cache controller: lookup, read-miss fill, write-through
module cache_requester
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = CACHE_ADDR_WIDTH,
    parameter int DATA_WIDTH = CACHE_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_hit,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [DATA_WIDTH-1:0] cache_wdata,
    output logic                  cache_we,
    output logic                  cache_oe,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    input  logic                  cache_hit,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  hit_inc;
    logic                  miss_inc;

    assign hit_inc  = (state == CHECK) &&  cache_hit;
    assign miss_inc = (state == CHECK) && !cache_hit;

    // Outputs are registered: each transition loads the values the next state drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_hit    <= 1'b0;
            cache_addr  <= '0;
            cache_wdata <= '0;
            cache_we    <= 1'b0;
            cache_oe    <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            resp_valid <= 1'b0;
            cache_we   <= 1'b0;
            cache_oe   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q     <= req_addr;
                        data_q     <= req_wdata;
                        req_ready  <= 1'b0;
                        cache_addr <= req_addr;
                        if (req_write) begin
                            cache_we    <= 1'b1;
                            cache_wdata <= req_wdata;
                            state       <= WR_CACHE;
                        end else begin
                            cache_oe <= 1'b1;
                            state    <= LOOKUP;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                LOOKUP: begin
                    state <= CHECK;
                end
                CHECK: begin
                    if (cache_hit) begin
                        data_q     <= cache_rdata;
                        resp_valid <= 1'b1;
                        resp_rdata <= cache_rdata;
                        resp_hit   <= 1'b1;
                        state      <= RESP;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= addr_q;
                        state    <= MEM_RD;
                    end
                end
                MEM_RD: begin
                    if (mem_ack) begin
                        data_q      <= mem_rdata;
                        mem_req     <= 1'b0;
                        cache_we    <= 1'b1;
                        cache_addr  <= addr_q;
                        cache_wdata <= mem_rdata;
                        state       <= FILL;
                    end
                end
                FILL: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= data_q;
                    resp_hit   <= 1'b0;
                    state      <= RESP;
                end
                WR_CACHE: begin
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_addr  <= addr_q;
                    mem_wdata <= data_q;
                    state     <= WR_MEM;
                end
                WR_MEM: begin
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_hit   <= 1'b0;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc),
        .count (hit_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc),
        .count (miss_count)
    );

endmodule

// File: tb/tb_cache_requester.sv
// tb/tb_cache_requester.sv - scoreboard bench for cache_requester with cache and memory models
module tb_cache_requester;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_hit;
    logic [AW-1:0] cache_addr;
    logic [DW-1:0] cache_wdata;
    logic          cache_we;
    logic          cache_oe;
    logic [DW-1:0] cache_rdata = '0;
    logic          cache_hit = 1'b0;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    cache_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_hit    (resp_hit),
        .cache_addr  (cache_addr),
        .cache_wdata (cache_wdata),
        .cache_we    (cache_we),
        .cache_oe    (cache_oe),
        .cache_rdata (cache_rdata),
        .cache_hit   (cache_hit),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          hit;
        logic [CW-1:0] hc;
        logic [CW-1:0] mc;
    } exp_t;

    exp_t          sbq[$];
    exp_t          mon_e;
    int            total = 0;
    int            bad = 0;
    logic [CW-1:0] exp_hc = '0;
    logic [CW-1:0] exp_mc = '0;

    // Synchronous cache array: tag hit and data appear the cycle after output_enable.
    logic [DW-1:0] cache_mem [int];
    always @(posedge clk) begin
        if (cache_oe) begin
            cache_hit   <= cache_mem.exists(int'(cache_addr));
            cache_rdata <= cache_mem.exists(int'(cache_addr)) ? cache_mem[int'(cache_addr)] : '0;
        end
        if (cache_we) cache_mem[int'(cache_addr)] = cache_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    task automatic push(input logic [DW-1:0] d, input logic h);
        exp_t e;
        e.rdata = d; e.hit = h; e.hc = exp_hc; e.mc = exp_mc;
        sbq.push_back(e);
    endtask

    // Returns at the negedge of the first cycle after the accepting edge.
    task automatic accept(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic read_hit(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_hc = sat_inc(exp_hc);
        push(d, 1'b1);
        accept(1'b0, a, '0);
        check("hit_c1_oe_we", {30'd0, cache_oe, cache_we}, 32'h2);
        check("hit_c1_addr", 32'(cache_addr), 32'(a));
        @(negedge clk);
        check("hit_c2_nomem_noresp", {30'd0, mem_req, resp_valid}, 32'h0);
        @(negedge clk);
        check("hit_c3_resp_nomem", {30'd0, mem_req, resp_valid}, 32'h1);
        @(negedge clk);
    endtask

    task automatic read_miss(input logic [AW-1:0] a, input logic [DW-1:0] d, input int delay);
        int n = 0;
        exp_mc = sat_inc(exp_mc);
        push(d, 1'b0);
        accept(1'b0, a, '0);
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("miss_mem_req_cycle", 32'(n), 32'd2);
        check("miss_mem_cmd", {17'd0, mem_we, mem_addr}, {17'd0, 1'b0, a});
        repeat (delay) begin
            @(negedge clk);
            check("miss_mem_hold", {17'd0, mem_req, mem_we, mem_addr}, {17'd0, 1'b1, 1'b0, a});
        end
        mem_ack = 1'b1; mem_rdata = d;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = '0;
        check("fill_we_oe", {30'd0, cache_we, cache_oe}, 32'h2);
        check("fill_addr_data", {4'd0, cache_addr, cache_wdata}, {4'd0, a, d});
        check("fill_mem_req_low", 32'(mem_req), 32'd0);
        @(negedge clk);
        check("miss_resp_cycle", {31'd0, resp_valid}, 32'd1);
        check("miss_no_second_fill", {31'd0, cache_we}, 32'd0);
        @(negedge clk);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int delay);
        push('0, 1'b0);
        accept(1'b1, a, d);
        check("wr_c1_we_oe", {30'd0, cache_we, cache_oe}, 32'h2);
        check("wr_c1_addr_data", {4'd0, cache_addr, cache_wdata}, {4'd0, a, d});
        check("wr_c1_no_mem", 32'(mem_req), 32'd0);
        @(negedge clk);
        check("wr_c2_cache_we_low", 32'(cache_we), 32'd0);
        repeat (delay) begin
            check("wr_mem_hold", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, a, d});
            @(negedge clk);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("wr_resp_cycle", {30'd0, resp_valid, mem_req}, 32'h2);
        @(negedge clk);
    endtask

    // Monitor: pops one expectation per response strobe.
    always @(negedge clk) begin
        if (!rst) begin
            check("we_oe_exclusive", {31'd0, cache_we & cache_oe}, 32'd0);
            if (resp_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("resp_rdata", 32'(resp_rdata), 32'(mon_e.rdata));
                    check("resp_hit", 32'(resp_hit), 32'(mon_e.hit));
                    check("resp_hit_count", 32'(hit_count), 32'(mon_e.hc));
                    check("resp_miss_count", 32'(miss_count), 32'(mon_e.mc));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen_we;
        logic seen_resp;

        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_counters", {24'd0, hit_count, miss_count}, 32'd0);
        check("rst_resp", {15'd0, resp_valid, resp_rdata}, 32'd0);
        check("rst_ctrl", {28'd0, cache_we, cache_oe, mem_req, mem_we}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("req_ready_after_rst", 32'(req_ready), 32'd1);

        // Reset while a read miss waits on memory, then a stale ack.
        accept(1'b0, 12'h020, '0);
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort_mem_req_high", 32'(mem_req), 32'd1);
        #1 rst = 1'b1;
        #1 check("abort_mem_req_async", {30'd0, mem_req, req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = '0;
        seen_we = 1'b0; seen_resp = 1'b0;
        repeat (6) begin
            seen_we   = seen_we | cache_we;
            seen_resp = seen_resp | resp_valid;
            @(negedge clk);
        end
        check("late_ack_no_fill", 32'(seen_we), 32'd0);
        check("late_ack_no_resp", 32'(seen_resp), 32'd0);
        check("late_ack_counters", {24'd0, hit_count, miss_count}, 32'd0);

        read_miss(12'h010, 16'hBEEF, 3);
        check("miss_count_one", 32'(miss_count), 32'd1);
        read_hit(12'h010, 16'hBEEF);
        check("hit_count_one", 32'(hit_count), 32'd1);
        do_write(12'h3FF, 16'h1234, 5);
        check("write_counters_same", {24'd0, hit_count, miss_count}, {24'd0, 4'd1, 4'd1});
        read_hit(12'h3FF, 16'h1234);

        while (exp_hc < 4'hE) read_hit(12'h010, 16'hBEEF);
        check("hit_count_preload", 32'(hit_count), 32'hE);
        read_hit(12'h010, 16'hBEEF);
        read_hit(12'h010, 16'hBEEF);
        check("hit_count_saturated", 32'(hit_count), 32'hF);
        check("miss_count_unaffected", 32'(miss_count), 32'd1);

        n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_requester.md
# cache_requester

Initiator-side controller for the on-chip cache array. It accepts single-word CPU read and write requests over a valid/ready handshake. It drives the cache's addr/data/write_enable/output_enable port and services read misses from main memory with a request/acknowledge handshake. Writes are write-through and allocating (cache and memory both updated). Read misses fill the cache before responding.

## Interface
- ADDR_WIDTH, 12, word address width (matches cache)
- DATA_WIDTH, 16, data word width (matches cache)
- CNT_WIDTH, 16, width of hit/miss statistics counters

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  CPU request present
- req_ready  out  1  controller can accept a request (IDLE only)
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  request address
- req_wdata  in  DATA_WIDTH  write data
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  DATA_WIDTH  read data (0 for writes)
- resp_hit  out  1  read hit in cache (0 for misses and writes)
- cache_addr  out  ADDR_WIDTH  cache address
- cache_wdata  out  DATA_WIDTH  cache write data
- cache_we  out  1  cache write_enable
- cache_oe  out  1  cache output_enable
- cache_rdata  in  DATA_WIDTH  cache read data, valid the cycle after cache_oe
- cache_hit  in  1  cache tag match, valid the cycle after cache_oe
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write when mem_req
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_ack  in  1  memory completion; mem_rdata valid same cycle for reads
- mem_rdata  in  DATA_WIDTH  memory read data
- hit_count, miss_count  out  CNT_WIDTH  saturating read hit/miss counters

## Operation
- States: IDLE, LOOKUP, CHECK, MEM_RD, FILL, WR_CACHE, WR_MEM, RESP.
- IDLE: req_ready=1. On req_valid, capture addr/write/wdata.
  - Read goes to LOOKUP.
  - Write goes to WR_CACHE.
- LOOKUP: cache_oe=1 and cache_addr=captured addr for exactly one cycle, then CHECK.
- CHECK: sample cache_hit/cache_rdata.
  - Hit: latch data, resp_hit=1, increment hit_count, go to RESP.
  - Miss: increment miss_count, go to MEM_RD.
- MEM_RD: mem_req=1, mem_we=0, mem_addr=addr held stable. On mem_ack, latch mem_rdata and go to FILL.
- FILL: cache_we=1 with addr and latched data for one cycle, then RESP (resp_hit=0).
- WR_CACHE: cache_we=1 with addr/wdata for one cycle, then WR_MEM.
- WR_MEM: mem_req=1, mem_we=1, addr/wdata held. On mem_ack, go to RESP.
- RESP: resp_valid=1 for one cycle with resp_rdata/resp_hit, then IDLE. The response has no back-pressure.
- cache_we and cache_oe are never high together.
- mem_req and mem_addr/mem_wdata/mem_we change only on entry to or exit from MEM_RD/WR_MEM.
- Counters saturate at all-ones and do not wrap. Writes change neither counter.

## Timing
- Reset (async, immediate):
  - State goes to IDLE.
  - All outputs 0, including req_ready, counters, and resp_rdata.
  - req_ready rises in the first cycle after rst deasserts.
- Request accepted at edge E0 (req_valid & req_ready):
  - Read hit: LOOKUP in cycle 1, CHECK in cycle 2, resp_valid in cycle 3.
  - Read miss: mem_req from cycle 3. With mem_ack in cycle k, FILL is in cycle k+1 and resp_valid in cycle k+2.
  - Write: cache_we in cycle 1 and mem_req from cycle 2. With mem_ack in cycle k, resp_valid is in cycle k+1.
- Back-to-back requests: the next accept is possible in the cycle after RESP, so there is at most one outstanding request.
- mem_ack outside MEM_RD/WR_MEM is ignored.
- mem_ack in the first cycle of mem_req is legal.
- Reset during MEM_RD/WR_MEM drops mem_req immediately. A late mem_ack after reset is ignored and the cache is not filled.
- req_valid while req_ready=0 is ignored; the CPU holds it.
- Counter at max plus another event stays at max.

## Structure
- Package cache_pkg holds:
  - state enum (state_t, 3 bits)
  - default ADDR_WIDTH/DATA_WIDTH constants, shared with the cache
- Sub-module sat_counter (parameter WIDTH; inputs clk, rst, inc; output count), instantiated twice for hit_count and miss_count.
- FSM and the captured-request registers live in cache_requester.

## Test plan
- Reset mid-MEM_RD (rst pulse while mem_req=1) -> mem_req=0 asynchronously. A later mem_ack produces no cache_we, no resp_valid, and counters stay 0.
- Read 0x010 on cold cache (cache_hit=0), memory acks with 0xBEEF after 3 cycles:
  - mem_req=1 with mem_addr=0x010.
  - Then one cache_we cycle with addr 0x010 / data 0xBEEF.
  - resp_valid with rdata=0xBEEF, resp_hit=0, miss_count=1.
- Read 0x010 again with cache model returning hit and 0xBEEF -> resp_valid exactly 3 cycles after accept, resp_hit=1, no mem_req, hit_count=1.
- Write 0x3FF=0x1234, mem_ack delayed 5 cycles:
  - One cache_we cycle, then mem_req/mem_we with addr 0x3FF and data 0x1234 held stable until ack.
  - resp_valid next cycle, rdata=0, counters unchanged.
- Preload hit_count=0xFFFE by 2 hits -> hit_count reads 0xFFFF and stays there; miss_count unaffected.
